keypad_entry_ctrl: RTL

- Sequences raw keypad scan results into a multi-digit hex entry.
- Input side: the matrix-scan decoder's 4-bit key code and its pressed level. That level is held and retriggered while a key is down.
- Handles press detection, digit shifting, backspace, long-press clear, inactivity timeout, and commit.
- Output side: the LCD/SPI front end consumes a live echo plus a committed value over a valid/ready handshake.

---
 rtl/keypad_entry_ctrl_pkg.sv | 14 +
 rtl/keypad_entry_ctrl_if.sv | 29 ++
 rtl/keypad_entry_ctrl_key_event_detect.sv | 46 ++++
 rtl/keypad_entry_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared keypad constants, controller state encoding and width helper.
// Pure declarations; imported by every keypad block.
package keypad_pkg;

    localparam logic [3:0] KEY_BKSP  = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    typedef enum logic {ENTRY, COMMIT} state_t;

    function automatic int cnt_w(input int digits);
        return $clog2(digits + 1);
    endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Display echo plus committed-value valid/ready channel toward the LCD/SPI front end.
// master = entry controller, slave = consumer (drives out_ready).
interface keypad_entry_ctrl_if #(parameter int DIGITS = 4) ();
    import keypad_pkg::*;

    localparam int CW = cnt_w(DIGITS);

    logic [4*DIGITS-1:0] disp_data;
    logic [CW-1:0]       disp_count;
    logic                disp_upd;
    logic [4*DIGITS-1:0] out_data;
    logic [CW-1:0]       out_count;
    logic                out_valid;
    logic                out_ready;
    logic                err;

    modport master (
        output disp_data, disp_count, disp_upd,
        output out_data, out_count, out_valid, err,
        input  out_ready
    );

    modport slave (
        input  disp_data, disp_count, disp_upd,
        input  out_data, out_count, out_valid, err,
        output out_ready
    );

endinterface

// File: rtl/keypad_entry_ctrl_key_event_detect.sv
// Press-edge detector with code capture and long-press backspace hold timer.
// press/code are combinational in the edge cycle; hold_fire pulses once per hold.
module key_event_detect
    import keypad_pkg::*;
#(
    parameter int CLR_HOLD_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key_code,
    input  logic       key_pressed,
    output logic       press,
    output logic [3:0] code,
    output logic       hold_fire
);

    localparam int HW = $clog2(CLR_HOLD_CYCLES + 1);

    logic          prev_q;
    logic [3:0]    code_q;
    logic [HW-1:0] hold_q;
    logic          is_bksp;

    assign press     = key_pressed & ~prev_q;
    assign code      = press ? key_code : code_q;
    assign is_bksp   = (code == KEY_BKSP);
    assign hold_fire = key_pressed && is_bksp && (hold_q == HW'(CLR_HOLD_CYCLES - 1));

    // Saturating one past the fire point so a long hold clears only once.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prev_q <= 1'b0;
            code_q <= '0;
            hold_q <= '0;
        end else begin
            prev_q <= key_pressed;
            if (press)
                code_q <= key_code;
            if (!key_pressed)
                hold_q <= '0;
            else if (is_bksp && hold_q != HW'(CLR_HOLD_CYCLES))
                hold_q <= hold_q + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Hex entry sequencer: digits, backspace, long-press clear, idle timeout, commit.
// Press edge to disp_data = 1 cycle, disp_upd 1 cycle later; out_valid holds until out_ready.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int TIMEOUT_CYCLES  = 500_000_000,
    parameter int CLR_HOLD_CYCLES = 100_000_000
) (
    input  logic                 clk,
    input  logic                 sys_rst_n,
    input  logic [3:0]           key_code,
    input  logic                 key_pressed,
    keypad_entry_ctrl_if.master  ent
);

    localparam int DW = 4 * DIGITS;
    localparam int CW = cnt_w(DIGITS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          press, hold_fire;
    logic [3:0]    code;

    state_t        state_q, state_d;
    logic [DW-1:0] buf_q, buf_d, odata_q, odata_d;
    logic [CW-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          oval_q, oval_d;
    logic          err_q, err_d;
    logic          chg, chg_q, upd_q;

    key_event_detect #(.CLR_HOLD_CYCLES(CLR_HOLD_CYCLES)) u_evt (
        .clk         (clk),
        .sys_rst_n   (sys_rst_n),
        .key_code    (key_code),
        .key_pressed (key_pressed),
        .press       (press),
        .code        (code),
        .hold_fire   (hold_fire)
    );

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        odata_d = odata_q;
        ocnt_d  = ocnt_q;
        oval_d  = oval_q;
        err_d   = 1'b0;
        chg     = 1'b0;
        case (state_q)
            ENTRY: begin
                if (press) begin
                    tmr_d = '0;
                    if (code == KEY_BKSP) begin
                        if (cnt_q != '0) begin
                            buf_d = buf_q >> 4;
                            cnt_d = cnt_q - 1'b1;
                            chg   = 1'b1;
                        end
                    end else if (code == KEY_ENTER) begin
                        if (cnt_q != '0) begin
                            odata_d = buf_q;
                            ocnt_d  = cnt_q;
                            oval_d  = 1'b1;
                            state_d = COMMIT;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (cnt_q < CW'(DIGITS)) begin
                        buf_d = {buf_q[DW-5:0], code};
                        cnt_d = cnt_q + 1'b1;
                        chg   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cnt_q != '0 && (hold_fire || tmr_q == TW'(TIMEOUT_CYCLES - 1))) begin
                    buf_d = '0;
                    cnt_d = '0;
                    tmr_d = '0;
                    chg   = 1'b1;
                end else if (cnt_q != '0) begin
                    tmr_d = tmr_q + 1'b1;
                end else begin
                    tmr_d = '0;
                end
            end
            COMMIT: begin
                // Timer frozen; any key here is a rejected key, even in the accept cycle.
                if (press)
                    err_d = 1'b1;
                if (oval_q && ent.out_ready) begin
                    oval_d  = 1'b0;
                    buf_d   = '0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    state_d = ENTRY;
                    chg     = (cnt_q != '0);
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ENTRY;
            buf_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            odata_q <= '0;
            ocnt_q  <= '0;
            oval_q  <= 1'b0;
            err_q   <= 1'b0;
            chg_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            odata_q <= odata_d;
            ocnt_q  <= ocnt_d;
            oval_q  <= oval_d;
            err_q   <= err_d;
            chg_q   <= chg;
            upd_q   <= chg_q;
        end
    end

    assign ent.disp_data  = buf_q;
    assign ent.disp_count = cnt_q;
    assign ent.disp_upd   = upd_q;
    assign ent.out_data   = odata_q;
    assign ent.out_count  = ocnt_q;
    assign ent.out_valid  = oval_q;
    assign ent.err        = err_q;

endmodule
